mac_tree_sched: RTL and testbench
=================================

Name: mac_tree_sched

Overview:
- Traversal scheduler for the 5-input 8-bit MAC datapath.
- Walks a decision tree held in an external node memory, one node at a time.
- For each internal node it fetches five coefficients and a threshold, drives the MAC with the latched attributes, and branches on the MAC result.
- At a leaf it reports the class.

Parameters:
- NODE_AW, 6, node-memory address width.
- ROOT_ADDR, 0, address of the tree root.
- MAX_DEPTH, 16, maximum internal nodes visited before the traversal aborts with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a traversal; sampled only in IDLE.
- attr_in  in  40  five 8-bit attributes. A1=[7:0] … A5=[39:32]. Latched when start is accepted.
- node_rd  out  1  node-memory read strobe.
- node_addr  out  NODE_AW  node-memory read address.
- node_data  in  57+2*NODE_AW  node word, valid the cycle after node_rd. Packing from LSB:
  - coef c1..c5 = [39:0]
  - threshold = [55:40]
  - leaf = [56]
  - left child = next NODE_AW bits
  - right child = next NODE_AW bits
  - For a leaf, class = [7:0].
- mac_attr  out  40  registered attributes to the MAC A1..A5 inputs.
- mac_coef  out  40  registered coefficients to the MAC c1..c5 inputs.
- mac_out  in  16  registered MAC result; valid one clk after the operands are stable.
- busy  out  1  high from start acceptance until the done/err cycle, inclusive.
- done  out  1  one-cycle pulse; class_out is valid.
- err  out  1  one-cycle pulse; depth limit exceeded.
- class_out  out  8  leaf class; held until the next accepted start.

Behaviour:
- Reset:
  - rst asserted clears everything asynchronously, at any point including mid-traversal.
  - Reset values: state=IDLE, all outputs 0, step counter 0, class_out 0.
  - Any in-progress traversal is discarded.
- States:
  - IDLE:
    - On start=1: latch attr_in into mac_attr, set the address register to ROOT_ADDR, clear the step counter, go to FETCH.
    - start is ignored in every other state.
  - FETCH: node_rd=1, node_addr=current address; go to LOAD.
  - LOAD: node_data is valid.
    - If leaf=1: class_out <= node_data[7:0]; go to DONE.
    - Else: capture mac_coef, threshold, left and right children; go to ISSUE.
  - ISSUE:
    - MAC operands are stable; the MAC captures at the end of this cycle.
    - If step counter == MAX_DEPTH: go to ERR. Else go to CMP.
  - CMP:
    - Compare mac_out to threshold as 16-bit unsigned.
    - mac_out >= threshold selects the right child; otherwise the left child.
    - Increment the step counter; go to FETCH.
  - DONE: done=1, busy=1; go to IDLE.
  - ERR: err=1, busy=1, class_out unchanged; go to IDLE.
- Latency, counting cycles after the start-accept edge:
  - Leaf root: done high in cycle 3.
  - Each internal node adds 4 cycles (FETCH, LOAD, ISSUE, CMP).
- The MAC result is truncated to 16 bits by the datapath. The scheduler compares the truncated value and performs no overflow detection.
- mac_attr stays constant for the whole traversal. mac_coef holds its last value after completion.
- Child addresses wrap modulo 2^NODE_AW. Self-loops are legal and are bounded by MAX_DEPTH.
- start asserted in the same cycle as a done/err pulse is ignored; it is accepted the following cycle in IDLE.

Optional Feature:
- Macro: MAC_TREE_PATH_TRACE_EN.
- When defined, adds two outputs:
  - path_bits [MAX_DEPTH-1:0]: branch decision per level (1=right), shifted in at CMP, LSB = first decision.
  - path_len [$clog2(MAX_DEPTH+1)-1:0]: count of internal nodes visited.
  - Both clear on rst and on start acceptance, and are held after done/err.
- When undefined: ports absent, no trace logic.

Test Plan:
- Leaf root: node0 leaf, class=0x2A; pulse start -> done high exactly 3 cycles later, class_out=0x2A, busy low the cycle after, err never asserted.
- Two-level tree, right branch:
  - Setup: attr=1,2,3,4,5; node0 coefs all 1, threshold 15, left=1, right=2; node1 leaf class 0x11; node2 leaf class 0x22.
  - Response: mac_out=15 >= 15 -> class_out=0x22, done 7 cycles after start.
- Same tree, threshold 16 -> class_out=0x11 (left branch). With trace enabled: path_bits=0, path_len=1.
- Depth abort: node0 internal with left=right=0 -> err pulse after MAX_DEPTH internal visits; class_out retains its prior value; done never asserted.
- start pulsed repeatedly while busy -> exactly one done; attributes from the first start are used.
- rst asserted during ISSUE of the first node -> outputs clear immediately; the next start completes normally with the correct class.

Source files
------------

// File: rtl/mac_tree_sched.sv
// rtl/mac_tree_sched.sv - decision-tree traversal scheduler driving a 5-input 8-bit MAC
// Optional branch-path trace outputs enabled by defining MAC_TREE_PATH_TRACE_EN.
module mac_tree_sched #(
    parameter int NODE_AW   = 6,
    parameter int ROOT_ADDR = 0,
    parameter int MAX_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [39:0]                    attr_in,
    output logic                           node_rd,
    output logic [NODE_AW-1:0]             node_addr,
    input  logic [57+2*NODE_AW-1:0]        node_data,
    output logic [39:0]                    mac_attr,
    output logic [39:0]                    mac_coef,
    input  logic [15:0]                    mac_out,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
`ifdef MAC_TREE_PATH_TRACE_EN
    output logic [MAX_DEPTH-1:0]           path_bits,
    output logic [$clog2(MAX_DEPTH+1)-1:0] path_len,
`endif
    output logic [7:0]                     class_out
);

    localparam int SW = $clog2(MAX_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_CMP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]         state;
    logic [NODE_AW-1:0] addr_q;
    logic [NODE_AW-1:0] left_q;
    logic [NODE_AW-1:0] right_q;
    logic [15:0]        thr_q;
    logic [SW-1:0]      step_q;
    logic               node_leaf;
    logic               go_right;

    assign node_leaf = node_data[56];
    assign go_right  = (mac_out >= thr_q);

    // Handshake outputs decode straight from the state register so reset clears them at once.
    assign node_rd   = (state == S_FETCH);
    assign node_addr = addr_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            thr_q     <= '0;
            step_q    <= '0;
            mac_attr  <= '0;
            mac_coef  <= '0;
            class_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mac_attr <= attr_in;
                        addr_q   <= NODE_AW'(ROOT_ADDR);
                        step_q   <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    if (node_leaf) begin
                        class_out <= node_data[7:0];
                        state     <= S_DONE;
                    end else begin
                        mac_coef <= node_data[39:0];
                        thr_q    <= node_data[55:40];
                        left_q   <= node_data[57 +: NODE_AW];
                        right_q  <= node_data[57+NODE_AW +: NODE_AW];
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (step_q == SW'(MAX_DEPTH)) begin
                        state <= S_ERR;
                    end else begin
                        state <= S_CMP;
                    end
                end
                S_CMP: begin
                    addr_q <= go_right ? right_q : left_q;
                    step_q <= step_q + SW'(1);
                    state  <= S_FETCH;
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MAC_TREE_PATH_TRACE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            path_bits <= '0;
            path_len  <= '0;
        end else if (state == S_IDLE && start) begin
            path_bits <= '0;
            path_len  <= '0;
        end else if (state == S_CMP) begin
            // Decision k lands in bit k, so the first branch is the LSB.
            path_bits <= path_bits | (MAX_DEPTH'(go_right) << step_q);
            path_len  <= path_len + SW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_tree_sched.sv
// tb/tb_mac_tree_sched.sv - directed scoreboard bench for mac_tree_sched
module tb_mac_tree_sched;

    localparam int AW   = 6;
    localparam int MAXD = 16;
    localparam int NW   = 57 + 2 * AW;
    localparam int SW   = $clog2(MAXD + 1);

    typedef struct {
        logic [7:0]      cls;
        logic            is_err;
        int              lat;
        logic [MAXD-1:0] pb;
        logic [SW-1:0]   pl;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [39:0]     attr_in;
    logic            node_rd;
    logic [AW-1:0]   node_addr;
    logic [NW-1:0]   node_data;
    logic [39:0]     mac_attr;
    logic [39:0]     mac_coef;
    logic [15:0]     mac_out;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      class_out;
`ifdef MAC_TREE_PATH_TRACE_EN
    logic [MAXD-1:0] path_bits;
    logic [SW-1:0]   path_len;
`endif

    logic [NW-1:0] mem [64];
    exp_t          sb [$];
    int            ntests = 0;
    int            nfail  = 0;
    int            dcount = 0;
    logic [7:0]    last_cls = 8'h00;

    always #5 clk = ~clk;

    mac_tree_sched #(.NODE_AW(AW), .ROOT_ADDR(0), .MAX_DEPTH(MAXD)) dut (
        .clk(clk), .rst(rst), .start(start), .attr_in(attr_in),
        .node_rd(node_rd), .node_addr(node_addr), .node_data(node_data),
        .mac_attr(mac_attr), .mac_coef(mac_coef), .mac_out(mac_out),
        .busy(busy), .done(done), .err(err),
`ifdef MAC_TREE_PATH_TRACE_EN
        .path_bits(path_bits), .path_len(path_len),
`endif
        .class_out(class_out)
    );

    function automatic logic [15:0] mac16(input logic [39:0] a, input logic [39:0] c);
        logic [15:0] s = 16'd0;
        for (int i = 0; i < 5; i++) s = s + 16'(a[8*i +: 8] * c[8*i +: 8]);
        return s;
    endfunction

    function automatic logic [NW-1:0] mk_int(input logic [39:0] c, input logic [15:0] thr,
                                             input logic [AW-1:0] l, input logic [AW-1:0] r);
        return {r, l, 1'b0, thr, c};
    endfunction

    function automatic logic [NW-1:0] mk_leaf(input logic [7:0] cls);
        return {{(2*AW){1'b0}}, 1'b1, 48'd0, cls};
    endfunction

    // Node memory and MAC stand-ins: one-cycle read, one-cycle registered MAC.
    always @(posedge clk) begin
        if (node_rd) node_data <= mem[node_addr];
        mac_out <= mac16(mac_attr, mac_coef);
        if (done) dcount <= dcount + 1;
    end

    function automatic exp_t model(input logic [39:0] a, input logic [7:0] prior);
        exp_t          e;
        logic [AW-1:0] ad;
        logic [NW-1:0] w;
        logic          right;
        int            step;
        ad = '0; step = 0;
        e.cls = prior; e.is_err = 1'b0; e.lat = 0; e.pb = '0; e.pl = '0;
        for (int g = 0; g < 1000; g++) begin
            w = mem[ad];
            e.lat += 2;
            if (w[56]) begin
                e.lat += 1;
                e.cls = w[7:0];
                return e;
            end
            e.lat += 1;
            if (step == MAXD) begin
                e.lat += 1;
                e.is_err = 1'b1;
                return e;
            end
            e.lat += 1;
            right = (mac16(a, w[39:0]) >= w[55:40]);
            if (right) e.pb = e.pb | (MAXD'(1) << step);
            ad = right ? w[NW-1 -: AW] : w[57 +: AW];
            step++;
            e.pl = SW'(step);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_trav(input logic [39:0] a);
        attr_in = a;
        sb.push_back(model(a, last_cls));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done/err; with jam set, start and attr_in are toggled while busy.
    task automatic wait_result(input string tag, input bit jam);
        int   n;
        exp_t e;
        n = 1;
        while (!(done || err) && n < 300) begin
            if (jam) begin
                start   = n[0];
                attr_in = {$urandom, 8'h00};
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!(done || err)) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 64'(n), 64'(e.lat));
            chk({tag, "_err"}, 64'(err), 64'(e.is_err));
            chk({tag, "_done"}, 64'(done), 64'(!e.is_err));
            chk({tag, "_class"}, 64'(class_out), 64'(e.cls));
`ifdef MAC_TREE_PATH_TRACE_EN
            chk({tag, "_pbits"}, 64'(path_bits), 64'(e.pb));
            chk({tag, "_plen"}, 64'(path_len), 64'(e.pl));
`endif
            last_cls = e.cls;
            @(negedge clk);
            chk({tag, "_busy_after"}, 64'(busy), 64'd0);
            chk({tag, "_pulse_after"}, 64'({done, err}), 64'd0);
        end
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 64; i++) mem[i] = mk_leaf(8'h00);
        node_data = '0;
        mac_out   = '0;
        rst = 1'b1; start = 1'b0; attr_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_node_rd", 64'(node_rd), 64'd0);
        chk("rst_addr", 64'(node_addr), 64'd0);
        chk("rst_class", 64'(class_out), 64'd0);
        chk("rst_mac", 64'({mac_attr, mac_coef}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        mem[0] = mk_leaf(8'h2A);
        start_trav(40'h0102030405);
        wait_result("leaf_root", 1'b0);

        mem[0] = mk_int({5{8'd1}}, 16'd15, 6'd1, 6'd2);
        mem[1] = mk_leaf(8'h11);
        mem[2] = mk_leaf(8'h22);
        start_trav({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        wait_result("right_br", 1'b0);
        chk("right_attr", 64'(mac_attr), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
        chk("right_coef_hold", 64'(mac_coef), 64'({5{8'd1}}));

        mem[0] = mk_int({5{8'd1}}, 16'd16, 6'd1, 6'd2);
        start_trav({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        wait_result("left_br", 1'b0);

        mem[3] = mk_int({8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 16'd4000, 6'd1, 6'd2);
        mem[0] = mk_int({5{8'd1}}, 16'd0, 6'd1, 6'd3);
        start_trav({5{8'd255}});
        wait_result("wrap_mac", 1'b0);

        mem[0] = mk_int({5{8'd3}}, 16'd20, 6'd0, 6'd0);
        start_trav({8'd1, 8'd9, 8'd1, 8'd9, 8'd1});
        d0 = dcount;
        wait_result("depth_abort", 1'b0);
        chk("depth_no_done", 64'(dcount - d0), 64'd0);

        mem[0] = mk_int({5{8'd1}}, 16'd15, 6'd1, 6'd2);
        d0 = dcount;
        start_trav({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        wait_result("jam_start", 1'b1);
        repeat (8) @(negedge clk);
        chk("jam_one_done", 64'(dcount - d0), 64'd1);
        chk("jam_attr_first", 64'(mac_attr), 64'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
        chk("jam_idle", 64'(busy), 64'd0);

        start_trav({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        repeat (2) @(negedge clk);
        chk("issue_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_outs", 64'({done, err, node_rd}), 64'd0);
        chk("midrst_class", 64'(class_out), 64'd0);
        chk("midrst_mac", 64'({mac_attr, mac_coef}), 64'd0);
        sb.delete();
        last_cls = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem[0] = mk_int({5{8'd1}}, 16'd16, 6'd1, 6'd2);
        start_trav({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        wait_result("post_rst", 1'b0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
